// File: rtl/mult32_seq.sv
// ---------------------------------------------------------------------------
// mult32_seq
//
// Sequential 32x32 multiplier for the RV32M MUL / MULH / MULHSU / MULHU
// instructions. A single combinational 16x16 unsigned multiplier (Mult16U)
// is reused over four cycles to build the 64-bit unsigned magnitude
// product. A final cycle applies the sign and selects the requested half.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rstn    in   1      asynchronous active-low reset
//   start   in   1      request, sampled only while idle
//   kill    in   1      pipeline flush, aborts any operation (beats start)
//   op      in   2      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1     in   WIDTH  operand A, captured with start
//   rs2     in   WIDTH  operand B, captured with start
//   busy    out  1      high while an operation is in flight
//   done    out  1      one-cycle pulse, result valid in that cycle
//   result  out  WIDTH  selected product half, held until the next done
//
// Optional feature macro: MULT32_ZERO_BYPASS_EN
//   When defined, an operation with a zero operand skips the four multiply
//   steps and finishes with latency 2 instead of 5. Results are identical.
// ---------------------------------------------------------------------------

// Combinational 16x16 unsigned multiplier shared by the sequential unit.
module Mult16U (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] result
);
    assign result = a * b;
endmodule

module mult32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic        neg_q, neg_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        sign_a;
    logic        sign_b;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic [31:0] mult_p;
    logic [63:0] pp_shifted;
    logic [63:0] product;

    Mult16U u_mult16 (
        .a      (mult_a),
        .b      (mult_b),
        .result (mult_p)
    );

    // rs1 is signed for MULH and MULHSU, rs2 only for MULH. Negating
    // 0x80000000 in 32 bits yields 0x80000000, which is the correct
    // unsigned magnitude 2^31.
    assign sign_a = ((op == OP_MULH) || (op == OP_MULHSU)) && rs1[31];
    assign sign_b = (op == OP_MULH) && rs2[31];

    // Partial-product selection by step: lo*lo, lo*hi, hi*lo, hi*hi.
    always_comb begin
        mult_a     = mag_a_q[15:0];
        mult_b     = mag_b_q[15:0];
        pp_shifted = {32'd0, mult_p};
        case (step_q)
            2'd0: begin
                mult_a     = mag_a_q[15:0];
                mult_b     = mag_b_q[15:0];
                pp_shifted = {32'd0, mult_p};
            end
            2'd1: begin
                mult_a     = mag_a_q[15:0];
                mult_b     = mag_b_q[31:16];
                pp_shifted = {16'd0, mult_p, 16'd0};
            end
            2'd2: begin
                mult_a     = mag_a_q[31:16];
                mult_b     = mag_b_q[15:0];
                pp_shifted = {16'd0, mult_p, 16'd0};
            end
            default: begin
                mult_a     = mag_a_q[31:16];
                mult_b     = mag_b_q[31:16];
                pp_shifted = {mult_p, 32'd0};
            end
        endcase
    end

    assign product = neg_q ? (64'd0 - acc_q) : acc_q;

    // Next-state logic. kill is applied last so it overrides every state,
    // suppressing done and leaving result untouched.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        op_d     = op_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    mag_a_d = sign_a ? (32'd0 - rs1) : rs1;
                    mag_b_d = sign_b ? (32'd0 - rs2) : rs2;
                    neg_d   = sign_a ^ sign_b;
                    acc_d   = 64'd0;
                    step_d  = 2'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
`ifdef MULT32_ZERO_BYPASS_EN
                // A zero magnitude means a zero product: leave the cleared
                // accumulator as-is and go straight to the fix-up cycle.
                if ((step_q == 2'd0) && ((mag_a_q == 32'd0) || (mag_b_q == 32'd0))) begin
                    state_d = S_FIX;
                end else begin
                    acc_d  = acc_q + pp_shifted;
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_d = S_FIX;
                    end
                end
`else
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = S_FIX;
                end
`endif
            end
            S_FIX: begin
                result_d = (op_q == OP_MUL) ? product[31:0] : product[63:32];
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // All architectural state, reset asynchronously to idle with zero outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            step_q   <= 2'd0;
            op_q     <= 2'd0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            neg_q    <= 1'b0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            op_q     <= op_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_MUL) || (state_q == S_FIX);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mult32_seq.sv
// ---------------------------------------------------------------------------
// tb_mult32_seq
//
// Self-checking bench for mult32_seq. Expected results come from a 64-bit
// arithmetic reference of the RV32M multiply rules; expected latency follows
// MULT32_ZERO_BYPASS_EN in the same way as the design build.
// ---------------------------------------------------------------------------
module tb_mult32_seq;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_compared;
    int n_mismatched;

    mult32_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sign-extend operands per RV32M rules, multiply in 64 bits.
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = ((o == 2'b01) || (o == 2'b10)) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = (o == 2'b01) ? longint'($signed(b)) : longint'({32'd0, b});
        p  = sa * sb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT32_ZERO_BYPASS_EN
        return ((a == 32'd0) || (b == 32'd0)) ? 2 : 5;
`else
        return 5;
`endif
    endfunction

    // Issue one operation from just after a clock edge; returns the observed
    // result and latency in cycles (-1 if done never arrived).
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        r = result;
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        rs1   = 32'd0;
        rs2   = 32'd0;
        #3;
        n_compared++;
        if ({busy, done, result} !== 34'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: busy=%b done=%b result=%h, required all 0",
                     busy, done, result);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] r;
        logic [31:0] held;
        int          lat;
        logic [1:0]  ops[5]  = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b10};
        logic [31:0] as[5]   = '{32'h00001234, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bs[5]   = '{32'h00005678, 32'h00000007, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] exps[5] = '{32'h06260060, 32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF};
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat);
            n_compared++;
            if (r !== exps[i]) begin
                n_mismatched++;
                $display("[TB] FAIL directed_result[%0d]: got %h, required %h", i, r, exps[i]);
            end
            n_compared++;
            if (lat != 5) begin
                n_mismatched++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d, required 5", i, lat);
            end
            n_compared++;
            if (busy !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL busy_in_done_cycle[%0d]: got %b, required 0", i, busy);
            end
            held = r;
            @(posedge clk);
            #1;
            n_compared++;
            if (done !== 1'b0 || result !== held) begin
                n_mismatched++;
                $display("[TB] FAIL done_pulse_hold[%0d]: done=%b result=%h, required done=0 result=%h",
                         i, done, result, held);
            end
        end
    endtask

    task automatic test_zero_operand();
        logic [31:0] r;
        int          lat;
        do_op(2'b00, 32'h00000000, 32'h12345678, r, lat);
        n_compared++;
        if (r !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL zero_result: got %h, required 00000000", r);
        end
        n_compared++;
        if (lat != ref_lat(32'd0, 32'h12345678)) begin
            n_mismatched++;
            $display("[TB] FAIL zero_latency: got %0d, required %0d", lat,
                     ref_lat(32'd0, 32'h12345678));
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'h80000000;
                2: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            do_op(o, a, b, r, lat);
            n_compared++;
            if (r !== ref_mul(o, a, b) || lat != ref_lat(a, b)) begin
                n_mismatched++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d, required %h lat %0d",
                         i, o, a, b, r, lat, ref_mul(o, a, b), ref_lat(a, b));
            end
        end
    endtask

    task automatic test_kill();
        logic [31:0] r;
        logic [31:0] prev;
        int          lat;
        int          dones;
        do_op(2'b00, 32'd3, 32'd3, r, lat);
        prev  = result;
        op    = 2'b00;
        rs1   = 32'd5;
        rs2   = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        n_compared++;
        if (busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL busy_mid_op: got %b, required 1", busy);
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        n_compared++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
            n_mismatched++;
            $display("[TB] FAIL kill_abort: busy=%b done=%b result=%h, required busy=0 done=0 result=%h",
                     busy, done, result, prev);
        end
        dones = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        n_compared++;
        if (dones != 0 || result !== prev) begin
            n_mismatched++;
            $display("[TB] FAIL kill_no_done: saw %0d done pulses result=%h, required 0 and %h",
                     dones, result, prev);
        end
        do_op(2'b00, 32'd5, 32'd7, r, lat);
        n_compared++;
        if (r !== 32'h00000023 || lat != 5) begin
            n_mismatched++;
            $display("[TB] FAIL after_kill: got %h lat %0d, required 00000023 lat 5", r, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int          lat;
        do_op(2'b11, 32'hDEADBEEF, 32'h12345678, r, lat);
        n_compared++;
        if (r !== ref_mul(2'b11, 32'hDEADBEEF, 32'h12345678) || lat != 5) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_first: got %h lat %0d, required %h lat 5", r, lat,
                     ref_mul(2'b11, 32'hDEADBEEF, 32'h12345678));
        end
        // Second start is raised while done of the first is still high.
        do_op(2'b01, 32'hF0000001, 32'h7FFFFFFF, r, lat);
        n_compared++;
        if (r !== ref_mul(2'b01, 32'hF0000001, 32'h7FFFFFFF) || lat != 5) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second: got %h lat %0d, required %h lat 5", r, lat,
                     ref_mul(2'b01, 32'hF0000001, 32'h7FFFFFFF));
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        int          lat;
        int          dones;
        do_op(2'b00, 32'd9, 32'd9, r, lat);
        op    = 2'b10;
        rs1   = 32'h87654321;
        rs2   = 32'h00ABCDEF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        n_compared++;
        if ({busy, done, result} !== 34'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_op: busy=%b done=%b result=%h, required all 0",
                     busy, done, result);
        end
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        dones = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        n_compared++;
        if (dones != 0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_no_done: saw %0d done pulses, required 0", dones);
        end
        do_op(2'b10, 32'h87654321, 32'h00ABCDEF, r, lat);
        n_compared++;
        if (r !== ref_mul(2'b10, 32'h87654321, 32'h00ABCDEF) || lat != 5) begin
            n_mismatched++;
            $display("[TB] FAIL after_reset: got %h lat %0d, required %h lat 5", r, lat,
                     ref_mul(2'b10, 32'h87654321, 32'h00ABCDEF));
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_directed();
        test_zero_operand();
        test_random();
        test_kill();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mult32_seq.md
# mult32_seq

Sequential 32x32 multiply unit for the RV32M `MUL`, `MULH`, `MULHSU` and `MULHU` instructions. It time-multiplexes one instance of the existing combinational `Mult16U` 16x16 unsigned multiplier over four cycles to form a 64-bit product. It applies RISC-V signedness rules and returns the selected 32-bit half to the execute stage through a start/done handshake. It sits between the core's execute stage and `Mult16U`: it produces `Mult16U`'s operands and consumes its `result`.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported. The `Mult16U` instance is fixed at 16 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only in IDLE.
- `kill`  in  1  pipeline flush. Aborts any operation in flight.
- `op`  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- `rs1`  in  32  operand A. Captured with `start`.
- `rs2`  in  32  operand B. Captured with `start`.
- `busy`  out  1  high while in MUL or FIX.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32  selected product half. Holds its value until the next `done`.

## Operation
- States are IDLE, MUL (with a 2-bit step counter), and FIX.
- **IDLE**
  - If `start` is high and `kill` is low: capture `op`.
  - Capture the absolute values of the operands as `mag_a` and `mag_b`.
    - `rs1` is treated as signed for MULH and MULHSU.
    - `rs2` is treated as signed for MULH only.
  - Capture `neg = sign_a ^ sign_b`, counting signs only for operands treated as signed.
  - Clear the 64-bit accumulator, set step to 0, and go to MUL.
- **MUL**
  - Each step drives `Mult16U` with one partial product and adds it, shifted, into the accumulator:
    - step 0: a_lo*b_lo, shift 0
    - step 1: a_lo*b_hi, shift 16
    - step 2: a_hi*b_lo, shift 16
    - step 3: a_hi*b_hi, shift 32
  - After step 3, go to FIX.
- **FIX**
  - If `neg` is set, the product is the two's complement of the accumulator (64-bit); otherwise it is the accumulator unchanged.
  - `result` gets product[31:0] for MUL, or product[63:32] for the other three operations.
  - Assert `done` and go to IDLE.
- Magnitude of 0x80000000 is 2^31. It is held unsigned in 32 bits, so no overflow.
- Accumulator is 64 bits. The sum never exceeds (2^32-1)^2, so no carry out.
- `kill` high in any state forces IDLE in the next cycle, with no `done`. `result` keeps its previous value. `kill` has priority over `start`.
- `start` is ignored while `busy` is high.
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0x00000000, accumulator 0.
- Reset asserted mid-operation returns the block to IDLE immediately (asynchronously). No `done` is produced.

## Timing
- `start` is sampled at edge E0.
- Partial products accumulate at edges E1 to E4.
- `result` is registered and `done` rises at edge E5. Latency is 5 cycles from the start edge to `done`.
- `busy` is high from after E0 until E5. In the `done` cycle, `busy` is low.
- Back-to-back operation: `start` may be asserted in the `done` cycle. Sustained throughput is one operation per 5 cycles.
- The `Mult16U` path is combinational within one cycle, from the registered operand halves to the accumulator adder.

## Configuration
- Macro: `MULT32_ZERO_BYPASS_EN`.
- Defined: if either captured magnitude is zero in IDLE, go directly to FIX with a zero accumulator. `done` then rises at E2, giving a latency of 2.
- Undefined: all operations take 5 cycles regardless of operand values.
- Results are identical in both configurations; only latency differs.

## Test plan
- MUL, rs1=0x00001234, rs2=0x00005678 -> `result`=0x06260060, with `done` exactly 5 cycles after start.
- MUL, rs1=0xFFFFFFFD (-3), rs2=0x00000007 -> `result`=0xFFFFFFEB.
- Corner values:
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Kill test:
  - Start MUL 5x7 and assert `kill` at cycle 2. No `done` is produced, `busy` is low the next cycle, and `result` is unchanged.
  - Then start MUL 5x7 -> `result`=0x00000023.
- Start asserted in the `done` cycle of a prior op: the second op is accepted and its `done` follows 5 cycles later. Assert `rstn` low mid-operation -> all outputs are 0 immediately.
- MUL 0x00000000 x 0x12345678 -> `result`=0. Latency is 2 with `MULT32_ZERO_BYPASS_EN` defined and 5 without it.
